data_memory_moc: RTL and testbench

Byte-addressed, big-endian data/instruction memory with a MOV/MOC handshake, sitting directly downstream of the microprogrammed control unit. It consumes the control register's MOV, R/W and size lines plus the MAR/MDR values, performs the access after a programmable number of wait states, and returns MOC, which the control unit's condition mux samples to leave its memory-wait microstates. It also has a byte preload port so benches can load program images.

---
 rtl/data_memory_moc_if.sv | 28 ++
 rtl/data_memory_moc.sv | 133 +++++++++++++
 tb/tb_data_memory_moc.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_moc_if.sv
// Memory-side bus between the control unit (MAR/MDR/MOV lines) and data_memory_moc.
// Also carries the byte preload port used to load program images.
interface data_memory_moc_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  MOV;
    logic                  RW;
    logic [1:0]            Size;
    logic [31:0]           Addr;
    logic [31:0]           DataIn;
    logic                  LoadEn;
    logic [ADDR_WIDTH-1:0] LoadAddr;
    logic [7:0]            LoadData;
    logic [31:0]           DataOut;
    logic                  MOC;
    logic                  Busy;
    logic                  AlignErr;

    modport master (
        output MOV, RW, Size, Addr, DataIn, LoadEn, LoadAddr, LoadData,
        input  DataOut, MOC, Busy, AlignErr
    );

    modport slave (
        input  MOV, RW, Size, Addr, DataIn, LoadEn, LoadAddr, LoadData,
        output DataOut, MOC, Busy, AlignErr
    );
endinterface

// File: rtl/data_memory_moc.sv
// Byte-addressed big-endian memory with MOV/MOC handshake and programmable wait states.
// A request is registered on the acceptance edge; the FSM leaves IDLE on the following edge.
module data_memory_moc #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              reset,
    data_memory_moc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state, next_state;
    logic                  go;
    logic                  rearm;
    logic [3:0]            cnt;
    logic                  rw_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           din_q;
    logic [31:0]           dout_q;
    logic                  err_q;
    logic [7:0]            mem [0:(1<<ADDR_WIDTH)-1];

    logic                  accept;
    logic                  enter_done;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    logic [31:0]           rdata;
    logic                  unused_addr;

    assign unused_addr = ^bus.Addr[31:ADDR_WIDTH];

    // Holding MOV high never starts a second access: rearm needs MOV seen low.
    assign accept     = (state == IDLE) && !go && bus.MOV && rearm;
    assign enter_done = (next_state == DONE) && (state != DONE) && !reset;

    assign a1 = addr_q + ADDR_WIDTH'(1);
    assign a2 = addr_q + ADDR_WIDTH'(2);
    assign a3 = addr_q + ADDR_WIDTH'(3);

    always_comb begin
        misaligned = 1'b0;
        rdata      = 32'd0;
        case (size_q)
            2'b00: rdata = {24'd0, mem[addr_q]};
            2'b01: begin
                misaligned = addr_q[0];
                rdata      = {16'd0, mem[addr_q], mem[a1]};
            end
            default: begin
                misaligned = |addr_q[1:0];
                rdata      = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (go) next_state = (WAIT_STATES == 0) ? DONE : WAIT;
            WAIT: if (cnt == 4'd0) next_state = DONE;
            DONE: if (!bus.MOV) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.MOC      = (state == DONE);
        bus.Busy     = (state != IDLE);
        bus.AlignErr = err_q;
        bus.DataOut  = dout_q;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            go     <= 1'b0;
            rearm  <= 1'b1;
            cnt    <= 4'd0;
            rw_q   <= 1'b0;
            size_q <= 2'b00;
            addr_q <= '0;
            din_q  <= 32'd0;
            dout_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            go <= accept;
            if (!bus.MOV)   rearm <= 1'b1;
            else if (accept) rearm <= 1'b0;
            if (accept) begin
                rw_q   <= bus.RW;
                size_q <= bus.Size;
                addr_q <= bus.Addr[ADDR_WIDTH-1:0];
                din_q  <= bus.DataIn;
            end
            if (go && WAIT_STATES > 0)          cnt <= 4'(WAIT_STATES - 1);
            else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (enter_done) begin
                err_q <= misaligned;
                if (misaligned) dout_q <= 32'd0;
                else if (rw_q)  dout_q <= rdata;
            end else if (state == DONE && !bus.MOV) begin
                err_q <= 1'b0;
            end
        end
    end

    // Memory is deliberately not reset; a committed write survives a later reset.
    always_ff @(posedge Clk) begin
        if (enter_done && !misaligned && !rw_q) begin
            case (size_q)
                2'b00: mem[addr_q] <= din_q[7:0];
                2'b01: begin
                    mem[addr_q] <= din_q[15:8];
                    mem[a1]     <= din_q[7:0];
                end
                default: begin
                    mem[addr_q] <= din_q[31:24];
                    mem[a1]     <= din_q[23:16];
                    mem[a2]     <= din_q[15:8];
                    mem[a3]     <= din_q[7:0];
                end
            endcase
        end else if (!reset && state == IDLE && !accept && bus.LoadEn) begin
            mem[bus.LoadAddr] <= bus.LoadData;
        end
    end
endmodule

// File: tb/tb_data_memory_moc.sv
// Bench for data_memory_moc: two instances (2 and 0 wait states) checked against a byte-array model.
module tb_data_memory_moc;
    localparam int AW = 9;
    localparam int DEPTH = 1 << AW;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    always #5 Clk = ~Clk;

    data_memory_moc_if #(.ADDR_WIDTH(AW)) ifa (), ifb ();

    data_memory_moc #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut_a (.Clk(Clk), .reset(reset), .bus(ifa.slave));
    data_memory_moc #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_b (.Clk(Clk), .reset(reset), .bus(ifb.slave));

    logic [7:0] ma [DEPTH];
    logic [7:0] mb [DEPTH];
    int nchk = 0;
    int nerr = 0;

    function automatic int ws(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    function automatic logic moc(input int sel);
        return (sel == 0) ? ifa.MOC : ifb.MOC;
    endfunction
    function automatic logic busy(input int sel);
        return (sel == 0) ? ifa.Busy : ifb.Busy;
    endfunction
    function automatic logic aerr(input int sel);
        return (sel == 0) ? ifa.AlignErr : ifb.AlignErr;
    endfunction
    function automatic logic [31:0] dout(input int sel);
        return (sel == 0) ? ifa.DataOut : ifb.DataOut;
    endfunction

    function automatic logic [7:0] mget(input int sel, input int a);
        return (sel == 0) ? ma[a % DEPTH] : mb[a % DEPTH];
    endfunction
    task automatic mset(input int sel, input int a, input logic [7:0] v);
        if (sel == 0) ma[a % DEPTH] = v;
        else          mb[a % DEPTH] = v;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Big-endian, zero-extended read straight from the byte array.
    function automatic logic [31:0] mread(input int sel, input logic [1:0] sz, input logic [31:0] addr);
        logic [31:0] v;
        int a;
        a = int'(addr % DEPTH);
        v = 32'd0;
        for (int i = 0; i < nbytes(sz); i++) v = (v << 8) | 32'(mget(sel, a + i));
        return v;
    endfunction

    task automatic drive(input int sel, input bit mov, input bit rw, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] din,
                         input bit ld, input logic [AW-1:0] la, input logic [7:0] ldat);
        if (sel == 0) begin
            ifa.MOV = mov; ifa.RW = rw; ifa.Size = sz; ifa.Addr = addr; ifa.DataIn = din;
            ifa.LoadEn = ld; ifa.LoadAddr = la; ifa.LoadData = ldat;
        end else begin
            ifb.MOV = mov; ifb.RW = rw; ifb.Size = sz; ifb.Addr = addr; ifb.DataIn = din;
            ifb.LoadEn = ld; ifb.LoadAddr = la; ifb.LoadData = ldat;
        end
    endtask

    // One full handshake: accept, latency check, optional hold with MOV high, release.
    task automatic access(input int sel, input bit rw, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] din, input int hold, input bit ld,
                          input logic [AW-1:0] la, input logic [7:0] ldat,
                          output logic [31:0] got, output logic gerr);
        int a, n, k;
        bit mis;
        logic [31:0] exp;
        a   = int'(addr % DEPTH);
        n   = nbytes(sz);
        mis = (a % n) != 0;
        exp = (mis || !rw) ? 32'd0 : mread(sel, sz, addr);
        drive(sel, 1'b1, rw, sz, addr, din, ld, la, ldat);
        @(negedge Clk);
        drive(sel, 1'b1, 1'($urandom), 2'($urandom), $urandom, $urandom, 1'b0, '0, 8'd0);
        nchk++;
        if (busy(sel) !== 1'b0 || moc(sel) !== 1'b0) begin
            nerr++; $display("FAIL accept_edge[%0d]: busy=%b moc=%b required 0 0", sel, busy(sel), moc(sel));
        end
        k = 0;
        while (moc(sel) !== 1'b1 && k < 40) begin
            @(negedge Clk);
            k++;
            if (k == 1) begin
                nchk++;
                if (busy(sel) !== 1'b1) begin
                    nerr++; $display("FAIL busy_rise[%0d]: busy=%b required 1", sel, busy(sel));
                end
            end
        end
        nchk++;
        if (k != 1 + ws(sel)) begin
            nerr++; $display("FAIL moc_latency[%0d]: edges=%0d required %0d", sel, k, 1 + ws(sel));
        end
        got  = dout(sel);
        gerr = aerr(sel);
        nchk++;
        if (gerr !== mis) begin
            nerr++; $display("FAIL align_err[%0d] a=%h sz=%0d: got %b required %b", sel, a, sz, gerr, mis);
        end
        if (rw || mis) begin
            nchk++;
            if (got !== exp) begin
                nerr++; $display("FAIL data_out[%0d] a=%h sz=%0d: got %h required %h", sel, a, sz, got, exp);
            end
        end
        if (!rw && !mis)
            for (int i = 0; i < n; i++) mset(sel, a + i, 8'(din >> (8 * (n - 1 - i))));
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            nchk++;
            if (moc(sel) !== 1'b1 || busy(sel) !== 1'b1 || ((rw || mis) && dout(sel) !== exp)) begin
                nerr++;
                $display("FAIL hold[%0d] cyc %0d: moc=%b busy=%b dout=%h required 1 1 %h",
                         sel, h, moc(sel), busy(sel), dout(sel), exp);
            end
        end
        drive(sel, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, '0, 8'd0);
        @(negedge Clk);
        nchk++;
        if (moc(sel) !== 1'b0 || busy(sel) !== 1'b0 || aerr(sel) !== 1'b0) begin
            nerr++; $display("FAIL release[%0d]: moc=%b busy=%b err=%b required 0 0 0", sel, moc(sel), busy(sel), aerr(sel));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, '0, 8'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, '0, 8'd0);
        repeat (3) @(negedge Clk);
        for (int s = 0; s < 2; s++) begin
            nchk++;
            if (moc(s) !== 1'b0 || busy(s) !== 1'b0 || aerr(s) !== 1'b0 || dout(s) !== 32'd0) begin
                nerr++; $display("FAIL reset_state[%0d]: moc=%b busy=%b err=%b dout=%h required all 0",
                                 s, moc(s), busy(s), aerr(s), dout(s));
            end
        end
        reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_preload();
        logic [7:0] va, vb;
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int i = 0; i < DEPTH; i++) begin
            va = (i >= 16 && i < 20) ? pat[i - 16] : 8'($urandom);
            vb = 8'($urandom);
            drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, AW'(i), va);
            drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, AW'(i), vb);
            mset(0, i, va);
            mset(1, i, vb);
            @(negedge Clk);
        end
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, '0, 8'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, '0, 8'd0);
        @(negedge Clk);
    endtask

    task automatic test_plan_reads();
        logic [31:0] g;
        logic e;
        logic [31:0] want [6];
        logic [31:0] have [6];
        access(0, 1'b1, 2'd2, 32'h10, 32'd0, 0, 1'b0, '0, 8'd0, have[0], e);
        access(0, 1'b1, 2'd0, 32'h12, 32'd0, 0, 1'b0, '0, 8'd0, have[1], e);
        access(0, 1'b1, 2'd1, 32'h12, 32'd0, 0, 1'b0, '0, 8'd0, have[2], e);
        access(0, 1'b0, 2'd0, 32'h11, 32'hAABBCCDD, 0, 1'b0, '0, 8'd0, g, e);
        access(0, 1'b1, 2'd2, 32'h10, 32'd0, 0, 1'b0, '0, 8'd0, have[3], e);
        access(0, 1'b1, 2'd1, 32'h11, 32'd0, 0, 1'b0, '0, 8'd0, have[4], e);
        nchk++;
        if (e !== 1'b1) begin
            nerr++; $display("FAIL plan_misaligned_half: err=%b required 1", e);
        end
        access(0, 1'b1, 2'd2, 32'h10, 32'd0, 10, 1'b0, '0, 8'd0, have[5], e);
        want[0] = 32'h11223344; want[1] = 32'h00000033; want[2] = 32'h00003344;
        want[3] = 32'h11DD3344; want[4] = 32'h00000000; want[5] = 32'h11DD3344;
        for (int i = 0; i < 6; i++) begin
            nchk++;
            if (have[i] !== want[i]) begin
                nerr++; $display("FAIL plan_read_%0d: got %h required %h", i, have[i], want[i]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] g;
        logic e;
        drive(0, 1'b1, 1'b0, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, '0, 8'd0);
        @(negedge Clk);
        @(negedge Clk);
        nchk++;
        if (busy(0) !== 1'b1) begin
            nerr++; $display("FAIL wait_busy: busy=%b required 1", busy(0));
        end
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, '0, 8'd0);
        @(negedge Clk);
        nchk++;
        if (moc(0) !== 1'b0 || busy(0) !== 1'b0 || aerr(0) !== 1'b0 || dout(0) !== 32'd0) begin
            nerr++; $display("FAIL reset_in_wait: moc=%b busy=%b err=%b dout=%h required all 0",
                             moc(0), busy(0), aerr(0), dout(0));
        end
        reset = 1'b0;
        @(negedge Clk);
        access(0, 1'b1, 2'd2, 32'h10, 32'd0, 0, 1'b0, '0, 8'd0, g, e);
        nchk++;
        if (g !== 32'h11DD3344) begin
            nerr++; $display("FAIL aborted_write: got %h required 11dd3344", g);
        end
    endtask

    task automatic test_mov_wins();
        logic [31:0] g;
        logic e;
        logic [7:0] old;
        old = mget(0, 9'h30);
        access(0, 1'b1, 2'd0, 32'h20, 32'd0, 0, 1'b1, 9'h30, ~old, g, e);
        access(0, 1'b1, 2'd0, 32'h30, 32'd0, 0, 1'b0, '0, 8'd0, g, e);
        nchk++;
        if (g !== {24'd0, old}) begin
            nerr++; $display("FAIL mov_wins: got %h required %h", g, {24'd0, old});
        end
    endtask

    task automatic test_wrap_ws0();
        logic [31:0] g;
        logic e;
        logic [31:0] w;
        w = {mb[16], mb[17], mb[18], mb[19]};
        access(1, 1'b1, 2'd2, 32'h00000210, 32'd0, 0, 1'b0, '0, 8'd0, g, e);
        nchk++;
        if (g !== w) begin
            nerr++; $display("FAIL addr_wrap: got %h required %h", g, w);
        end
        access(1, 1'b0, 2'd1, 32'hFFFF_FFFE, 32'h1234_5678, 0, 1'b0, '0, 8'd0, g, e);
        access(1, 1'b1, 2'd3, 32'h0000_01FC, 32'd0, 0, 1'b0, '0, 8'd0, g, e);
        nchk++;
        if (g[15:0] !== 16'h5678) begin
            nerr++; $display("FAIL top_half_write: got %h required low half 5678", g);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] g;
        logic e;
        for (int i = 0; i < 6; i++)
            access(i % 2, 1'($urandom), 2'($urandom), $urandom, $urandom, 0, 1'b0, '0, 8'd0, g, e);
    endtask

    task automatic test_random();
        logic [31:0] g;
        logic e;
        for (int i = 0; i < 80; i++)
            access(int'($urandom_range(1, 0)), 1'($urandom), 2'($urandom), $urandom, $urandom,
                   int'($urandom_range(2, 0)), 1'b0, '0, 8'd0, g, e);
    endtask

    initial begin
        test_reset();
        test_preload();
        test_plan_reads();
        test_reset_in_wait();
        test_mov_wins();
        test_wrap_ws0();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
